// File: rtl/dmem_pkg.sv
// Shared types and helpers for the load/store data-memory responder.
package dmem_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Misaligned or beyond-the-end word index; indices never alias.
  function automatic logic addr_err(input logic [WORD_W-1:0] addr, input int unsigned depth);
    logic [WORD_W-1:0] w_idx;
    w_idx = {2'b00, addr[WORD_W-1:2]};
    return (addr[1:0] != 2'b00) || (w_idx >= depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-wide storage: synchronous write, combinational read. Contents survive reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// Request/ack responder around dmem_array with programmable wait states and
// registered ack/err/rdata; bad addresses are flagged rather than aliased.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic              ack,
  output logic [WORD_W-1:0] rdata,
  output logic              err,
  output logic              busy
);

  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  LAT = 4'(LATENCY);

  state_t            r_state, w_next;
  logic [3:0]        r_cnt, w_cnt_next;
  logic              r_we;
  logic [WORD_W-1:0] r_addr, r_wdata;
  logic              r_ack, r_err, r_busy;
  logic [WORD_W-1:0] r_rdata;

  logic              w_take, w_enter_resp;
  logic              w_we, w_err, w_ram_we;
  logic [WORD_W-1:0] w_addr, w_wdata, w_ram_rdata, w_rdata_next;

  // With LATENCY=0 the response edge is the acceptance edge, so the live
  // inputs are used; otherwise the latched copy drives the access.
  assign w_take  = (r_state == IDLE) && req;
  assign w_we    = (r_state == IDLE) ? we    : r_we;
  assign w_addr  = (r_state == IDLE) ? addr  : r_addr;
  assign w_wdata = (r_state == IDLE) ? wdata : r_wdata;
  assign w_err   = addr_err(w_addr, DEPTH);
  assign w_ram_we = w_enter_resp && w_we && !w_err;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_addr[AW+1:2]),
    .i_wdata (w_wdata),
    .o_rdata (w_ram_rdata)
  );

  // Next-state and wait-counter logic.
  always_comb begin
    w_next       = r_state;
    w_cnt_next   = r_cnt;
    w_enter_resp = 1'b0;
    case (r_state)
      IDLE: begin
        if (req) begin
          w_cnt_next = LAT;
          if (LAT == 4'd0) begin
            w_next       = RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_next = WAIT;
          end
        end else begin
          w_next = IDLE;
        end
      end
      WAIT: begin
        if (r_cnt <= 4'd1) begin
          w_next       = RESP;
          w_enter_resp = 1'b1;
          w_cnt_next   = 4'd0;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      RESP: begin
        w_next = IDLE;
      end
      default: begin
        w_next     = IDLE;
        w_cnt_next = 4'd0;
      end
    endcase
  end

  // Read data is captured only for a clean load on the response edge.
  always_comb begin
    if (w_enter_resp && !w_we && !w_err) begin
      w_rdata_next = w_ram_rdata;
    end else begin
      w_rdata_next = {WORD_W{1'b0}};
    end
  end

  // State, request latch and registered response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= {WORD_W{1'b0}};
      r_wdata <= {WORD_W{1'b0}};
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= {WORD_W{1'b0}};
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_take) begin
        r_we    <= we;
        r_addr  <= addr;
        r_wdata <= wdata;
      end
      r_ack   <= w_enter_resp;
      r_err   <= w_enter_resp && w_err;
      r_rdata <= w_rdata_next;
      r_busy  <= (w_next != IDLE);
    end
  end

  assign ack   = r_ack;
  assign err   = r_err;
  assign rdata = r_rdata;
  assign busy  = r_busy;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench: one responder with LATENCY=0, one with LATENCY=2.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req0, we0, ack0, err0, busy0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        req2, we2, ack2, err2, busy2;
  logic [31:0] addr2, wdata2, rdata2;

  int total = 0;
  int bad   = 0;

  // Reference memories indexed by word number.
  logic [31:0] model0 [1024];
  logic [31:0] model2 [1024];

  dmem_responder #(.DEPTH(1024), .LATENCY(0)) u_dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .ack(ack0), .rdata(rdata0), .err(err0), .busy(busy0)
  );

  dmem_responder #(.DEPTH(1024), .LATENCY(2)) u_dut2 (
    .clk(clk), .reset(reset), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
    .ack(ack2), .rdata(rdata2), .err(err2), .busy(busy2)
  );

  // Expected response from the access rules; updates the model on clean stores.
  task automatic model_access(input bit which, input bit w, input logic [31:0] a,
                              input logic [31:0] d, output logic [31:0] exp_rd,
                              output logic exp_e);
    exp_e  = (a % 4 != 0) || (a / 4 >= 1024);
    exp_rd = 32'h0;
    if (!exp_e) begin
      if (w) begin
        if (which) model2[a / 4] = d;
        else       model0[a / 4] = d;
      end else begin
        exp_rd = which ? model2[a / 4] : model0[a / 4];
      end
    end
  endtask

  // Runs one access; cyc = cycles from acceptance to ack (-1 if none).
  task automatic do_access(input bit which, input bit w, input logic [31:0] a,
                           input logic [31:0] d, output logic [31:0] rd,
                           output logic e, output int cyc, output logic busy_at_ack,
                           output logic tail_ok);
    @(negedge clk);
    if (which) begin req2 = 1'b1; we2 = w; addr2 = a; wdata2 = d; end
    else       begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    @(posedge clk);
    cyc = -1; rd = 32'h0; e = 1'b0; busy_at_ack = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (which ? ack2 : ack0) begin
        cyc = k;
        rd = which ? rdata2 : rdata0;
        e = which ? err2 : err0;
        busy_at_ack = which ? busy2 : busy0;
        break;
      end
    end
    if (which) req2 = 1'b0; else req0 = 1'b0;
    @(negedge clk);
    tail_ok = which ? (!ack2 && !busy2 && !err2 && rdata2 == 32'h0)
                    : (!ack0 && !busy0 && !err0 && rdata0 == 32'h0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0;
    req2 = 1'b0; we2 = 1'b0; addr2 = 32'h0; wdata2 = 32'h0;
    repeat (3) @(negedge clk);
    total++;
    if ({ack0, err0, busy0, rdata0} !== 35'h0) begin
      bad++; $display("FAIL reset_l0: got %h want 0", {ack0, err0, busy0, rdata0});
    end
    total++;
    if ({ack2, err2, busy2, rdata2} !== 35'h0) begin
      bad++; $display("FAIL reset_l2: got %h want 0", {ack2, err2, busy2, rdata2});
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_store_load_l2();
    logic [31:0] rd, xr; logic e, xe, b, t; int cyc;
    model_access(1'b1, 1'b1, 32'hFC4, 32'h400, xr, xe);
    do_access(1'b1, 1'b1, 32'hFC4, 32'h400, rd, e, cyc, b, t);
    total++; if (cyc !== 3) begin bad++; $display("FAIL l2_store_lat: got %0d want 3", cyc); end
    total++; if (e !== xe) begin bad++; $display("FAIL l2_store_err: got %b want %b", e, xe); end
    model_access(1'b1, 1'b0, 32'hFC4, 32'h0, xr, xe);
    do_access(1'b1, 1'b0, 32'hFC4, 32'h0, rd, e, cyc, b, t);
    total++; if (cyc !== 3) begin bad++; $display("FAIL l2_load_lat: got %0d want 3", cyc); end
    total++; if (rd !== xr) begin bad++; $display("FAIL l2_load_data: got %h want %h", rd, xr); end
    total++; if (t !== 1'b1) begin bad++; $display("FAIL l2_ack_one_cycle: got %b want 1", t); end
  endtask

  task automatic test_latency0();
    logic [31:0] rd, xr; logic e, xe, b, t; int cyc;
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL l0_idle_busy: got %b want 0", busy0); end
    model_access(1'b0, 1'b1, 32'h64, 32'h7, xr, xe);
    do_access(1'b0, 1'b1, 32'h64, 32'h7, rd, e, cyc, b, t);
    total++; if (cyc !== 1) begin bad++; $display("FAIL l0_store_lat: got %0d want 1", cyc); end
    total++; if ({b, t} !== 2'b11) begin bad++; $display("FAIL l0_store_busy: got %b want 11", {b, t}); end
    model_access(1'b0, 1'b0, 32'h64, 32'h0, xr, xe);
    do_access(1'b0, 1'b0, 32'h64, 32'h0, rd, e, cyc, b, t);
    total++; if (cyc !== 1) begin bad++; $display("FAIL l0_load_lat: got %0d want 1", cyc); end
    total++; if (rd !== xr) begin bad++; $display("FAIL l0_load_data: got %h want %h", rd, xr); end
    total++; if ({b, t} !== 2'b11) begin bad++; $display("FAIL l0_load_busy: got %b want 11", {b, t}); end
  endtask

  task automatic test_errors();
    logic [31:0] rd, xr; logic e, xe, b, t; int cyc;
    logic [31:0] alist [4] = '{32'h66, 32'h64, 32'h1000, 32'hFFC};
    logic        wlist [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic        which [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      model_access(which[i], wlist[i], alist[i], 32'hDEAD, xr, xe);
      do_access(which[i], wlist[i], alist[i], 32'hDEAD, rd, e, cyc, b, t);
      total++;
      if ({e, rd} !== {xe, xr}) begin
        bad++; $display("FAIL err_case%0d: got err=%b rdata=%h want err=%b rdata=%h", i, e, rd, xe, xr);
      end
    end
    model_access(1'b1, 1'b0, 32'hFFC, 32'h0, xr, xe);
    do_access(1'b1, 1'b0, 32'hFFC, 32'h0, rd, e, cyc, b, t);
    total++;
    if ({e, rd} !== {xe, xr}) begin
      bad++; $display("FAIL last_index_load: got err=%b rdata=%h want err=%b rdata=%h", e, rd, xe, xr);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, xr; logic e, xe, b, t; int cyc, t1, t2;
    model_access(1'b1, 1'b1, 32'h14, 32'h1234, xr, xe);
    do_access(1'b1, 1'b1, 32'h14, 32'h1234, rd, e, cyc, b, t);
    @(negedge clk);
    req2 = 1'b1; we2 = 1'b1; addr2 = 32'h10; wdata2 = 32'hA;
    @(posedge clk);
    @(negedge clk);
    addr2 = 32'h14; wdata2 = 32'h99;
    t1 = -1; t2 = -1;
    for (int k = 2; k <= 40; k++) begin
      @(negedge clk);
      if (ack2 && t1 < 0) begin
        t1 = k; addr2 = 32'h10; wdata2 = 32'hB;
      end else if (ack2) begin
        t2 = k; break;
      end
    end
    req2 = 1'b0;
    model_access(1'b1, 1'b1, 32'h10, 32'hA, xr, xe);
    model_access(1'b1, 1'b1, 32'h10, 32'hB, xr, xe);
    total++; if (t1 !== 3) begin bad++; $display("FAIL b2b_first_lat: got %0d want 3", t1); end
    total++; if (t2 - t1 !== 4) begin bad++; $display("FAIL b2b_spacing: got %0d want 4", t2 - t1); end
    @(negedge clk);
    model_access(1'b1, 1'b0, 32'h10, 32'h0, xr, xe);
    do_access(1'b1, 1'b0, 32'h10, 32'h0, rd, e, cyc, b, t);
    total++; if (rd !== xr) begin bad++; $display("FAIL b2b_final: got %h want %h", rd, xr); end
    model_access(1'b1, 1'b0, 32'h14, 32'h0, xr, xe);
    do_access(1'b1, 1'b0, 32'h14, 32'h0, rd, e, cyc, b, t);
    total++; if (rd !== xr) begin bad++; $display("FAIL b2b_wait_ignored: got %h want %h", rd, xr); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, xr; logic e, xe, b, t; int cyc;
    model_access(1'b1, 1'b1, 32'h20, 32'h77, xr, xe);
    do_access(1'b1, 1'b1, 32'h20, 32'h77, rd, e, cyc, b, t);
    @(negedge clk);
    req2 = 1'b1; we2 = 1'b1; addr2 = 32'h20; wdata2 = 32'h55;
    @(posedge clk);
    @(negedge clk);
    total++; if (busy2 !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1", busy2); end
    reset = 1'b0;
    #1;
    total++;
    if ({ack2, err2, busy2} !== 3'b000) begin
      bad++; $display("FAIL mid_reset_outs: got %b want 000", {ack2, err2, busy2});
    end
    req2 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_access(1'b1, 1'b0, 32'h20, 32'h0, xr, xe);
    do_access(1'b1, 1'b0, 32'h20, 32'h0, rd, e, cyc, b, t);
    total++; if (rd !== xr) begin bad++; $display("FAIL mid_no_write: got %h want %h", rd, xr); end
  endtask

  task automatic test_random();
    logic [31:0] rd, xr, a, d; logic e, xe, b, t, w, wh; int cyc, sel;
    logic [31:0] pool [8];
    for (int i = 0; i < 8; i++) begin
      pool[i] = 32'(($urandom_range(0, 1023)) * 4);
      for (int j = 0; j < 2; j++) begin
        wh = j[0];
        d = $urandom;
        model_access(wh, 1'b1, pool[i], d, xr, xe);
        do_access(wh, 1'b1, pool[i], d, rd, e, cyc, b, t);
      end
    end
    for (int n = 0; n < 60; n++) begin
      wh = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      sel = $urandom_range(0, 9);
      if (sel < 8) a = pool[sel];
      else if (sel == 8) a = pool[$urandom_range(0, 7)] + 32'($urandom_range(1, 3));
      else a = 32'h1000 + 32'($urandom_range(0, 4000000)) * 4;
      model_access(wh, w, a, d, xr, xe);
      do_access(wh, w, a, d, rd, e, cyc, b, t);
      total++;
      if ({cyc == (wh ? 3 : 1), e, rd, t} !== {1'b1, xe, xr, 1'b1}) begin
        bad++;
        $display("FAIL rand%0d: dut=L%0d we=%b addr=%h got cyc=%0d err=%b rdata=%h tail=%b want err=%b rdata=%h",
                 n, wh ? 2 : 0, w, a, cyc, e, rd, t, xe, xr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_load_l2();
    test_latency0();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
